// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and constants for the systolic array sequencer.
//   ctrl_state_t  : sequencer state (IDLE, CLEAR, FEED, READ, DONE)
//   DIM_DEFAULT   : default array dimension
//   FEED_STEPS    : feed window length for DIM_DEFAULT (3*DIM-2)
//   LAST_IN_STEP  : step at which the last operand enters (2*DIM-2)
//   feed_steps(), last_in_step() : the same constants for any DIM
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int DIM_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      READ  = 3'd3,
      DONE  = 3'd4
   } ctrl_state_t;

   // The last operand enters at 2*DIM-2 and needs DIM-1 more hops to reach
   // the far corner, so the feed window is 3*DIM-2 steps long.
   function automatic int feed_steps(input int dim);
      return 3 * dim - 2;
   endfunction

   function automatic int last_in_step(input int dim);
      return 2 * dim - 2;
   endfunction

   localparam int FEED_STEPS   = feed_steps(DIM_DEFAULT);
   localparam int LAST_IN_STEP = last_in_step(DIM_DEFAULT);

endpackage

// File: rtl/systolic_skew_mask.sv
// -----------------------------------------------------------------------------
// systolic_skew_mask
// Combinational skew decoder: bit i is set when lane i carries a real operand
// at feed step step_i, i.e. (step_i - i) lies in [0, DIM-1].
//   step_i : current feed step
//   mask_o : per-lane operand-valid mask (row for A, column for B)
// -----------------------------------------------------------------------------
module systolic_skew_mask #(
   parameter int DIM    = 8,
   parameter int STEP_W = $clog2(3 * DIM - 2)
) (
   input  logic [STEP_W-1:0] step_i,
   output logic [DIM-1:0]    mask_o
);

   always_comb begin
      mask_o = '0;
      for (int i = 0; i < DIM; i++) begin
         // Unsigned step is widened before the compare so step < i never wraps.
         mask_o[i] = (int'(step_i) >= i) && (int'(step_i) < i + DIM);
      end
   end

endmodule

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for a DIM x DIM systolic MAC array: optional accumulator clear,
// skewed operand feed over the full propagation window, row readback, done.
// Carries no data; produces only enables, masks and indices.
//   clk, rst          : clock, asynchronous active-high reset
//   start, clr_acc    : begin an operation (IDLE only), clear accumulators first
//   stall             : freeze sequencing in CLEAR/FEED/READ
//   busy, done        : not-IDLE, one-cycle completion pulse
//   mac_en, mac_wren, cin_zero : broadcast array controls
//   step, a_row_vld, b_col_vld : feed step and operand-valid masks
//   c_rd_row, c_rd_vld         : readback row index and its valid
//   dbg_state         : current sequencer state for observation
//
// Flow control: stall is a level hold, not a handshake. While stall=1 in
// CLEAR/FEED/READ the state and counters do not advance and every action
// strobe (mac_en, mac_wren, cin_zero, c_rd_vld) is gated off in that same
// cycle; step and masks keep showing the held position. start is a request
// sampled only in IDLE and is dropped, never queued, at any other time.
// -----------------------------------------------------------------------------
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int DIM    = DIM_DEFAULT,
   parameter int STEP_W = $clog2(3 * DIM - 2),
   parameter int IDX_W  = $clog2(DIM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              clr_acc,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic              mac_en,
   output logic              mac_wren,
   output logic              cin_zero,
   output logic [STEP_W-1:0] step,
   output logic [DIM-1:0]    a_row_vld,
   output logic [DIM-1:0]    b_col_vld,
   output logic [IDX_W-1:0]  c_rd_row,
   output logic              c_rd_vld,
   output ctrl_state_t       dbg_state
);

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(feed_steps(DIM) - 1);
   localparam logic [IDX_W-1:0]  ROW_LAST  = IDX_W'(DIM - 1);

   ctrl_state_t       state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [IDX_W-1:0]  row_q, row_d;
   logic [DIM-1:0]    a_mask, b_mask;

   systolic_skew_mask #(.DIM(DIM), .STEP_W(STEP_W)) u_a_mask (
      .step_i (step_q),
      .mask_o (a_mask)
   );

   systolic_skew_mask #(.DIM(DIM), .STEP_W(STEP_W)) u_b_mask (
      .step_i (step_q),
      .mask_o (b_mask)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         row_q   <= row_d;
      end
   end

   // Next-state logic. Counters are returned to 0 when their phase ends so
   // they read 0 outside their own state.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      row_d   = row_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = clr_acc ? CLEAR : FEED;
         end
         CLEAR: begin
            if (!stall) state_d = FEED;
         end
         FEED: begin
            if (!stall) begin
               if (step_q == STEP_LAST) begin
                  state_d = READ;
                  step_d  = '0;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         READ: begin
            if (!stall) begin
               if (row_q == ROW_LAST) begin
                  state_d = DONE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      mac_en    = 1'b0;
      mac_wren  = 1'b0;
      cin_zero  = 1'b0;
      c_rd_vld  = 1'b0;
      step      = step_q;
      c_rd_row  = row_q;
      a_row_vld = '0;
      b_col_vld = '0;
      dbg_state = state_q;
      case (state_q)
         CLEAR: begin
            mac_en   = !stall;
            mac_wren = !stall;
            cin_zero = !stall;
         end
         FEED: begin
            mac_en    = !stall;
            a_row_vld = a_mask;
            b_col_vld = b_mask;
         end
         READ: begin
            c_rd_vld = !stall;
         end
         default: begin
         end
      endcase
   end

endmodule
